serializador_parametrico: RTL



---
 rtl/serializador_parametrico_pkg.sv | 18 +
 rtl/serializador_parametrico_if.sv | 24 ++
 rtl/serializador_parametrico_registrador_deslocamento.sv | 30 +++
 rtl/serializador_parametrico.sv | 98 +++++++++
 4 files changed

// File: rtl/serializador_parametrico_pkg.sv
// Shared definitions for the serial converter family (serialiser now, deserialiser later).
// Holds the FSM state encoding and a constant clog2 helper used to size counters.
package serializador_parametrico_pkg;

  typedef enum logic {
    OCIOSO     = 1'b0,
    DESLOCANDO = 1'b1
  } estado_t;

  // Constant-foldable ceil(log2(valor)); valid for valor >= 1.
  function automatic int clog2_param(input int valor);
    int r;
    r = 0;
    while ((1 << r) < valor) r++;
    return r;
  endfunction

endpackage

// File: rtl/serializador_parametrico_if.sv
// Word-input handshake of the serialiser: producer (master) to serialiser (slave).
// Valid/ready: a word moves on a rising clock where entrada_valida and entrada_pronta are both 1;
// the producer holds entrada_valida and entrada_paralela steady until that edge.
interface serializador_parametrico_if #(
  parameter int LARGURA = 6
);

  logic               entrada_valida;
  logic               entrada_pronta;
  logic [LARGURA-1:0] entrada_paralela;

  modport master (
    output entrada_valida,
    output entrada_paralela,
    input  entrada_pronta
  );

  modport slave (
    input  entrada_valida,
    input  entrada_paralela,
    output entrada_pronta
  );

endinterface

// File: rtl/serializador_parametrico_registrador_deslocamento.sv
// Loadable LARGURA-bit shift register; bit_atual is always the next bit to leave.
// Load has priority over shift so a new word can replace the last bit in one edge.
module registrador_deslocamento_param #(
  parameter int LARGURA      = 6,
  parameter int MSB_PRIMEIRO = 0
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               carregar,
  input  logic               deslocar,
  input  logic [LARGURA-1:0] dado,
  output logic               bit_atual
);

  logic [LARGURA-1:0] reg_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      reg_q <= '0;
    end else if (carregar) begin
      reg_q <= dado;
    end else if (deslocar) begin
      if (MSB_PRIMEIRO != 0) reg_q <= {reg_q[LARGURA-2:0], 1'b0};
      else                   reg_q <= {1'b0, reg_q[LARGURA-1:1]};
    end
  end

  assign bit_atual = (MSB_PRIMEIRO != 0) ? reg_q[LARGURA-1] : reg_q[0];

endmodule

// File: rtl/serializador_parametrico.sv
// Parametrised parallel-to-serial converter: counter, FSM, optional holding buffer and handshake.
// One bit leaves per clock with habilitar=1; a buffered word follows with no idle gap.
module serializador_parametrico
  import serializador_parametrico_pkg::*;
#(
  parameter int LARGURA      = 6,
  parameter int MSB_PRIMEIRO = 0,
  parameter int BUFFER_DUPLO = 1
) (
  input  logic    clock,
  input  logic    reset,
  input  logic    habilitar,
  serializador_parametrico_if.slave entrada,
  output logic    saida_serial,
  output logic    saida_valida,
  output logic    saida_ultimo,
  output logic    ocupado,
  output estado_t estado_dbg
);

  localparam int LARG_CONT = clog2_param(LARGURA + 1);
  localparam logic [LARG_CONT-1:0] CONT_CHEIO = LARG_CONT'(LARGURA);
  localparam logic [LARG_CONT-1:0] CONT_UM    = LARG_CONT'(1);

  estado_t            estado_q;
  logic [LARG_CONT-1:0] contador_q;
  logic [LARGURA-1:0] buffer_q;
  logic               buffer_cheio_q;

  logic               aceite;
  logic               emitir;
  logic               ultimo_bit;
  logic               carga_buffer;
  logic               carregar_sr;
  logic               grava_buffer;
  logic [LARGURA-1:0] dado_sr;
  logic               bit_atual;

  assign entrada.entrada_pronta = (BUFFER_DUPLO != 0) ? !buffer_cheio_q : (estado_q == OCIOSO);

  assign aceite       = entrada.entrada_valida && entrada.entrada_pronta;
  assign emitir       = (estado_q == DESLOCANDO) && habilitar;
  assign ultimo_bit   = emitir && (contador_q == CONT_UM);
  assign carga_buffer = ultimo_bit && buffer_cheio_q;
  // A word arriving on the last-bit edge with an empty buffer goes straight to the shifter.
  assign carregar_sr  = ((estado_q == OCIOSO) && aceite) || carga_buffer || (ultimo_bit && aceite);
  assign grava_buffer = (BUFFER_DUPLO != 0) && aceite && (estado_q == DESLOCANDO) && !ultimo_bit;
  assign dado_sr      = buffer_cheio_q ? buffer_q : entrada.entrada_paralela;

  registrador_deslocamento_param #(
    .LARGURA      (LARGURA),
    .MSB_PRIMEIRO (MSB_PRIMEIRO)
  ) u_registrador (
    .clock     (clock),
    .reset     (reset),
    .carregar  (carregar_sr),
    .deslocar  (emitir),
    .dado      (dado_sr),
    .bit_atual (bit_atual)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado_q       <= OCIOSO;
      contador_q     <= '0;
      buffer_q       <= '0;
      buffer_cheio_q <= 1'b0;
      saida_serial   <= 1'b0;
      saida_valida   <= 1'b0;
      saida_ultimo   <= 1'b0;
    end else begin
      saida_valida <= emitir;
      saida_ultimo <= ultimo_bit;

      if (emitir) begin
        saida_serial <= bit_atual;
        contador_q   <= contador_q - CONT_UM;
      end
      if (carregar_sr) begin
        contador_q <= CONT_CHEIO;
        estado_q   <= DESLOCANDO;
      end else if (ultimo_bit) begin
        estado_q <= OCIOSO;
      end

      if (grava_buffer) begin
        buffer_q       <= entrada.entrada_paralela;
        buffer_cheio_q <= 1'b1;
      end else if (carga_buffer) begin
        buffer_cheio_q <= 1'b0;
      end
    end
  end

  assign ocupado    = (estado_q == DESLOCANDO) || buffer_cheio_q;
  assign estado_dbg = estado_q;

endmodule
